// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard scoreboard.
//   sb_entry_t  : one scoreboard entry (valid, wr, load, dst, rs, rt, use_rt)
//   FWD_REGFILE : forwarding-select value meaning "use the register-file value"
// Register-address fields are SB_AW bits wide; narrower REG_AW values are zero-extended
// into them, so REG_AW must not exceed SB_AW.
package pipe_pkg;

  localparam int unsigned SB_AW       = 8;
  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             load;
    logic [SB_AW-1:0] dst;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             use_rt;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding match of one E-stage source register against scoreboard entries
// 1..DEPTH-1. The lowest (youngest) qualifying entry wins; loads qualify only once they
// have reached LOAD_READY.
//   en   in  : operand is live (E instruction valid, and for rt, rt is a source)
//   src  in  : source register address
//   sb   in  : scoreboard contents, entry 0 = E
//   sel  out : 0 = register file, k = result held by entry k
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned FW         = $clog2(DEPTH)
) (
  input  logic                        en,
  input  logic [SB_AW-1:0]            src,
  input  sb_entry_t [DEPTH-1:0]       sb,
  output logic [FW-1:0]               sel
);

  // Entry 0 and the source fields of older entries are never matched here.
  logic unused_fields;

  always_comb begin
    unused_fields = ^sb[0];
    for (int k = 1; k < int'(DEPTH); k++) begin
      unused_fields = unused_fields ^ (^{sb[k].rs, sb[k].rt, sb[k].use_rt});
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel = FW'(FWD_REGFILE);
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (en && (src != '0) && sb[k].valid && sb[k].wr && (sb[k].dst == src) &&
          (!sb[k].load || (k >= int'(LOAD_READY)))) begin
        sel = FW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline. A shift-register
// scoreboard tracks the destination of every instruction past decode and drives
// E-stage forwarding selects, load-use stalls, branch flushes and external freeze.
//   clk, reset_n         : clock, asynchronous active-low reset
//   d_*_i                : decode-stage instruction fields
//   flush_i              : taken branch, bubble into E
//   ext_stall_i          : freeze whole pipeline, scoreboard holds
//   stall_f_o, stall_d_o : hold PC / fetch->decode register
//   flush_e_o            : bubble into decode->exec register
//   fwd_a_o, fwd_b_o     : E operand selects, 0 = register file, k = entry k result
// Optional build macro HAZARD_STATS_EN adds saturating stall_cnt_o / fwd_cnt_o counters.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  localparam int unsigned FW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid_i,
  input  logic [REG_AW-1:0] d_rs_i,
  input  logic [REG_AW-1:0] d_rt_i,
  input  logic              d_use_rt_i,
  input  logic [REG_AW-1:0] d_dst_i,
  input  logic              d_wr_i,
  input  logic              d_load_i,
  input  logic              flush_i,
  input  logic              ext_stall_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_e_o,
  output logic [FW-1:0]     fwd_a_o,
  output logic [FW-1:0]     fwd_b_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       fwd_cnt_o
`endif
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  sb_entry_t             dec_entry;
  logic [SB_AW-1:0]      rs_x, rt_x;
  logic                  seen_rs, seen_rt, hit_rs, hit_rt, lwstall;

  assign rs_x = SB_AW'(d_rs_i);
  assign rt_x = SB_AW'(d_rt_i);

  assign dec_entry = '{valid:  d_valid_i,
                       wr:     d_wr_i,
                       load:   d_load_i,
                       dst:    SB_AW'(d_dst_i),
                       rs:     rs_x,
                       rt:     rt_x,
                       use_rt: d_use_rt_i};

  // Load-use: the youngest writer of a decode source among entries that cannot yet
  // forward load data decides. A younger non-load writer shadows an older load.
  always_comb begin
    seen_rs = 1'b0;
    seen_rt = 1'b0;
    hit_rs  = 1'b0;
    hit_rt  = 1'b0;
    for (int j = 0; j <= int'(LOAD_READY) - 2; j++) begin
      if (!seen_rs && (rs_x != '0) && sb_q[j].valid && (sb_q[j].wr || sb_q[j].load) &&
          (sb_q[j].dst == rs_x)) begin
        seen_rs = 1'b1;
        hit_rs  = sb_q[j].load;
      end
      if (!seen_rt && d_use_rt_i && (rt_x != '0) && sb_q[j].valid &&
          (sb_q[j].wr || sb_q[j].load) && (sb_q[j].dst == rt_x)) begin
        seen_rt = 1'b1;
        hit_rt  = sb_q[j].load;
      end
    end
    lwstall = d_valid_i && (hit_rs || hit_rt);
  end

  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (ext_stall_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
    end else if (flush_i) begin
      flush_e_o = 1'b1;
    end else if (lwstall) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (!ext_stall_i) begin
      for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0] = (flush_i || lwstall) ? SB_BUBBLE : dec_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  fwd_select #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FW         (FW)
  ) u_fwd_a (
    .en  (sb_q[0].valid),
    .src (sb_q[0].rs),
    .sb  (sb_q),
    .sel (fwd_a_o)
  );

  fwd_select #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FW         (FW)
  ) u_fwd_b (
    .en  (sb_q[0].valid && sb_q[0].use_rt),
    .src (sb_q[0].rt),
    .sb  (sb_q),
    .sel (fwd_b_o)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (lwstall && !ext_stall_i && !flush_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (((fwd_a_o != FW'(FWD_REGFILE)) || (fwd_b_o != FW'(FWD_REGFILE))) && !ext_stall_i &&
          (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid, d_use_rt, d_wr, d_load, flush, ext_stall;
  logic [4:0] d_rs, d_rt, d_dst;
  logic       sf3, sd3, fe3, sf4, sd4, fe4;
  logic [1:0] fa3, fb3, fa4, fb4;
  logic [6:0] out3, out4;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc3, fc3, sc4, fc4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign out3 = {sf3, sd3, fe3, fa3, fb3};
  assign out4 = {sf4, sd4, fe4, fa4, fb4};

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_READY(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .d_valid_i(d_valid), .d_rs_i(d_rs), .d_rt_i(d_rt),
    .d_use_rt_i(d_use_rt), .d_dst_i(d_dst), .d_wr_i(d_wr), .d_load_i(d_load),
    .flush_i(flush), .ext_stall_i(ext_stall), .stall_f_o(sf3), .stall_d_o(sd3),
    .flush_e_o(fe3), .fwd_a_o(fa3), .fwd_b_o(fb3)
`ifdef HAZARD_STATS_EN
    , .stall_cnt_o(sc3), .fwd_cnt_o(fc3)
`endif
  );

  hazard_scoreboard #(.REG_AW(5), .DEPTH(4), .LOAD_READY(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .d_valid_i(d_valid), .d_rs_i(d_rs), .d_rt_i(d_rt),
    .d_use_rt_i(d_use_rt), .d_dst_i(d_dst), .d_wr_i(d_wr), .d_load_i(d_load),
    .flush_i(flush), .ext_stall_i(ext_stall), .stall_f_o(sf4), .stall_d_o(sd4),
    .flush_e_o(fe4), .fwd_a_o(fa4), .fwd_b_o(fb4)
`ifdef HAZARD_STATS_EN
    , .stall_cnt_o(sc4), .fwd_cnt_o(fc4)
`endif
  );

  // Directed vector: decode fields, flush/ext, expected {sf,sd,fe,fa,fb}.
  typedef struct {
    int v, rs, rt, u, dst, wr, ld, fl, ex;
    logic [6:0] exp;
  } vec_t;

  // Reference model: in-flight instruction list, index 0 = E.
  typedef struct {
    bit v, wr, ld, u;
    int rs, rt, dst;
  } ins_t;
  typedef ins_t sb_t [4];

  function automatic vec_t V(int v, int rs, int rt, int u, int dst, int wr, int ld, int fl,
                             int ex, int sf, int sd, int fe, int fa, int fb);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.u = u; t.dst = dst; t.wr = wr; t.ld = ld;
    t.fl = fl; t.ex = ex;
    t.exp = {1'(sf), 1'(sd), 1'(fe), 2'(fa), 2'(fb)};
    return t;
  endfunction

  function automatic vec_t BUB(int fa, int fb);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb);
  endfunction

  task automatic apply(input vec_t t);
    d_valid = 1'(t.v); d_rs = 5'(t.rs); d_rt = 5'(t.rt); d_use_rt = 1'(t.u);
    d_dst = 5'(t.dst); d_wr = 1'(t.wr); d_load = 1'(t.ld); flush = 1'(t.fl);
    ext_stall = 1'(t.ex);
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got sf/sd/fe=%b fa=%0d fb=%0d, expected sf/sd/fe=%b fa=%0d fb=%0d",
               name, got[6:4], got[3:2], got[1:0], exp[6:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_table(input vec_t tbl[$], input bit use4, input string tag);
    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("%s[%0d]", tag, i), use4 ? out4 : out3, tbl[i].exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    apply(BUB(0, 0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic int pick(input sb_t sb, input int depth, input int lr, input int r);
    if (r == 0) return 0;
    for (int k = 1; k < depth; k++) begin
      if (sb[k].v && sb[k].wr && sb[k].dst == r && (!sb[k].ld || k >= lr)) return k;
    end
    return 0;
  endfunction

  // Stall when the most recent in-flight writer of r is a load not yet forwardable next cycle.
  function automatic bit early_load(input sb_t sb, input int depth, input int lr, input int r);
    if (r == 0) return 1'b0;
    for (int j = 0; j < depth; j++) begin
      if (sb[j].v && (sb[j].wr || sb[j].ld) && sb[j].dst == r) return sb[j].ld && (j < lr - 1);
    end
    return 1'b0;
  endfunction

  function automatic void model_out(input sb_t sb, input int depth, input int lr,
                                    input ins_t dec, input bit fl, input bit ex,
                                    output logic [6:0] exp, output bit lw, output bit fw);
    int fa, fb;
    bit sf, fe;
    fa = sb[0].v ? pick(sb, depth, lr, sb[0].rs) : 0;
    fb = (sb[0].v && sb[0].u) ? pick(sb, depth, lr, sb[0].rt) : 0;
    lw = dec.v && (early_load(sb, depth, lr, dec.rs) ||
                   (dec.u && early_load(sb, depth, lr, dec.rt)));
    sf = ex || (!fl && lw);
    fe = !ex && (fl || lw);
    fw = (fa != 0) || (fb != 0);
    exp = {sf, sf, fe, 2'(fa), 2'(fb)};
  endfunction

  function automatic void model_next(input sb_t sb, input int depth, input ins_t dec,
                                     input bit fl, input bit ex, input bit lw,
                                     output sb_t nsb);
    ins_t empty = '{default: 0};
    nsb = sb;
    if (!ex) begin
      for (int k = depth - 1; k >= 1; k--) nsb[k] = sb[k-1];
      nsb[0] = (fl || lw || !dec.v) ? empty : dec;
    end
  endfunction

  vec_t t3[$], t4[$];
  sb_t  m3, m4;

  initial begin
    ins_t empty = '{default: 0};
    // DEPTH=3, LOAD_READY=2 directed scenarios
    t3.push_back(V(1,1,2,1,8,1,0,0,0, 0,0,0,0,0));   // add $8
    t3.push_back(V(1,8,1,1,9,1,0,0,0, 0,0,0,0,0));   // add $9,$8,$1
    t3.push_back(V(1,3,4,1,10,1,0,0,0, 0,0,0,1,0));  // consumer in E: fwd from M
    t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,2,1,8,1,0,0,0, 0,0,0,0,0));   // add $8
    t3.push_back(V(1,3,4,1,12,1,0,0,0, 0,0,0,0,0));  // unrelated
    t3.push_back(V(1,8,1,1,9,1,0,0,0, 0,0,0,0,0));   // consumer
    t3.push_back(BUB(2,0)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));   // lw $8
    t3.push_back(V(1,1,8,1,9,1,0,0,0, 1,1,1,0,0));   // add $9,$1,$8: stall
    t3.push_back(V(1,1,8,1,9,1,0,0,0, 0,0,0,0,0));   // released
    t3.push_back(BUB(0,2)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));   // lw $8
    t3.push_back(V(1,1,8,0,9,1,0,0,0, 0,0,0,0,0));   // addi, rt=8 not a source
    t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,2,1,0,1,0,0,0, 0,0,0,0,0));   // add $0
    t3.push_back(V(1,0,0,1,9,1,0,0,0, 0,0,0,0,0));   // uses $0
    t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,0,0,0,1,1,0,0, 0,0,0,0,0));   // lw $0
    t3.push_back(V(1,0,0,1,9,1,0,0,0, 0,0,0,0,0));   // uses $0: no stall
    t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));   // lw $8
    t3.push_back(V(1,1,8,1,9,1,0,0,1, 1,1,0,0,0));   // ext stall x3
    t3.push_back(V(1,1,8,1,9,1,0,0,1, 1,1,0,0,0));
    t3.push_back(V(1,1,8,1,9,1,0,0,1, 1,1,0,0,0));
    t3.push_back(V(1,1,8,1,9,1,0,0,0, 1,1,1,0,0));   // exactly one lwstall
    t3.push_back(V(1,1,8,1,9,1,0,0,0, 0,0,0,0,0));
    t3.push_back(BUB(0,2)); t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));   // lw $8
    t3.push_back(V(1,1,8,1,9,1,0,1,0, 0,0,1,0,0));   // flush overrides lwstall
    t3.push_back(BUB(0,0)); t3.push_back(BUB(0,0));
    t3.push_back(V(1,1,2,1,5,1,0,1,1, 1,1,0,0,0));   // ext beats flush
    t3.push_back(BUB(0,0));
    // DEPTH=4, LOAD_READY=3
    t4.push_back(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));   // lw $8
    t4.push_back(V(1,8,2,1,9,1,0,0,0, 1,1,1,0,0));   // two-cycle stall
    t4.push_back(V(1,8,2,1,9,1,0,0,0, 1,1,1,0,0));
    t4.push_back(V(1,8,2,1,9,1,0,0,0, 0,0,0,0,0));
    t4.push_back(BUB(3,0));
    t4.push_back(BUB(0,0)); t4.push_back(BUB(0,0)); t4.push_back(BUB(0,0));
    t4.push_back(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));   // lw $8
    t4.push_back(V(1,1,2,1,8,1,0,0,0, 0,0,0,0,0));   // add $8 shadows the load
    t4.push_back(V(1,8,3,1,9,1,0,0,0, 0,0,0,0,0));   // no stall
    t4.push_back(BUB(1,0));
    t4.push_back(BUB(0,0)); t4.push_back(BUB(0,0)); t4.push_back(BUB(0,0));

    reset_n = 1'b0;
    apply(BUB(0, 0));
    repeat (2) @(negedge clk);
    #1;
    check("reset3", out3, 7'd0);
    check("reset4", out4, 7'd0);
`ifdef HAZARD_STATS_EN
    check32("reset_stall_cnt", sc3, 32'd0);
    check32("reset_fwd_cnt", fc3, 32'd0);
`endif
    reset_n = 1'b1;

    run_table(t3, 1'b0, "dir3");

    // Reset asserted during a load-use stall drops it immediately.
    @(negedge clk);
    apply(V(1,1,8,0,8,1,1,0,0, 0,0,0,0,0));
    @(negedge clk);
    apply(V(1,1,8,1,9,1,0,0,0, 0,0,0,0,0));
    #1;
    check("midstall_pre", out3, 7'b1110000);
    #1 reset_n = 1'b0;
    #1;
    check("midstall_rst", out3, 7'd0);

    do_reset();
    run_table(t4, 1'b1, "dir4");

    do_reset();
    foreach (m3[i]) begin
      m3[i] = empty;
      m4[i] = empty;
    end
    begin
      logic [31:0] esc3 = 0, efc3 = 0;
      for (int c = 0; c < 600; c++) begin
        ins_t dec;
        bit fl, ex, lw3, lw4, fw3, fw4;
        logic [6:0] e3, e4;
        sb_t n3, n4;
        dec.v  = $urandom_range(0, 99) < 85;
        dec.rs = $urandom_range(0, 3);
        dec.rt = $urandom_range(0, 3);
        dec.u  = $urandom_range(0, 1) == 1;
        dec.dst = $urandom_range(0, 3);
        dec.ld = $urandom_range(0, 99) < 30;
        dec.wr = dec.ld || ($urandom_range(0, 99) < 75);
        fl = $urandom_range(0, 99) < 8;
        ex = $urandom_range(0, 99) < 10;
        @(negedge clk);
        apply(V(dec.v, dec.rs, dec.rt, dec.u, dec.dst, dec.wr, dec.ld, fl, ex, 0,0,0,0,0));
        #1;
        model_out(m3, 3, 2, dec, fl, ex, e3, lw3, fw3);
        model_out(m4, 4, 3, dec, fl, ex, e4, lw4, fw4);
        check($sformatf("rnd3 cyc%0d", c), out3, e3);
        check($sformatf("rnd4 cyc%0d", c), out4, e4);
        if (lw3 && !fl && !ex) esc3++;
        if (fw3 && !ex) efc3++;
        @(posedge clk);
        model_next(m3, 3, dec, fl, ex, lw3, n3);
        model_next(m4, 4, dec, fl, ex, lw4, n4);
        m3 = n3;
        m4 = n4;
      end
      @(negedge clk);
`ifdef HAZARD_STATS_EN
      check32("stall_cnt", sc3, esc3);
      check32("fwd_cnt", fc3, efc3);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order MIPS pipeline, successor to the fixed three-stage load-use/forwarding logic. It keeps a shift-register scoreboard of in-flight destination registers for every stage after decode. From that scoreboard it produces:
- per-operand forwarding selects for the execute stage;
- the load-use stall/bubble;
- flush handling for taken branches;
- a global external freeze.

Pipeline depth and load-result latency are parameters, so deeper memory stages need no new hazard logic.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- DEPTH, 3, scoreboard entries after decode (entry 0 = E, 1 = M, 2 = W for the default); minimum 2.
- LOAD_READY, 2, lowest entry index at which load data is forwardable; range 1..DEPTH-1.
- FW = $clog2(DEPTH), derived, width of forwarding selects.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- d_valid_i  in  1  decode stage holds a real instruction.
- d_rs_i  in  REG_AW  decode rs.
- d_rt_i  in  REG_AW  decode rt.
- d_use_rt_i  in  1  rt is a source operand (ALUSrc == 0 or store).
- d_dst_i  in  REG_AW  decode destination register.
- d_wr_i  in  1  decode instruction writes the register file.
- d_load_i  in  1  decode instruction is a load.
- flush_i  in  1  taken branch; kills decode and E occupants.
- ext_stall_i  in  1  freeze the whole pipeline (memory wait).
- stall_f_o  out  1  hold PC.
- stall_d_o  out  1  hold fetch→decode register.
- flush_e_o  out  1  insert bubble into decode→exec register.
- fwd_a_o  out  FW  E-stage rs select: 0 = register value, k = result of entry k.
- fwd_b_o  out  FW  E-stage rt select, same encoding.

## Operation
Each scoreboard entry holds valid, wr, load, dst. Entry 0 also holds rs, rt and use_rt of the E instruction.

Register 0 never matches anything.

Forwarding for operand A (B uses rt of entry 0 and is gated by entry 0 use_rt):
- Pick the lowest k in 1..DEPTH-1 with: entry k valid, wr, dst == rs, and (!load or k ≥ LOAD_READY).
- If no entry qualifies, the select is 0.

Load-use hazard (lwstall):
- Set when d_valid_i and some entry j in 0..LOAD_READY-2 is valid, load, with dst == d_rs_i, or dst == d_rt_i while d_use_rt_i is 1.
- A younger non-load match to the same register at a lower index masks the load match.

Output priority:
- ext_stall_i: stall_f_o = stall_d_o = 1, flush_e_o = 0. Scoreboard holds.
- flush_i: stall_f_o = stall_d_o = 0, flush_e_o = 1. Entry 0 ← bubble, others shift. lwstall is ignored.
- lwstall: stall_f_o = stall_d_o = flush_e_o = 1. Entry 0 ← bubble, others shift.
- Otherwise: entry 0 ← decode fields (valid = d_valid_i), others shift.

Entries shifted out past DEPTH-1 are discarded. The register file is write-before-read, so no decode bypass is needed.

## Timing
- All outputs are combinational from the scoreboard and the d_* inputs.
- The scoreboard updates on posedge clk.
- Load-use stall length is LOAD_READY-1 cycles (1 for the default).
- Asynchronous reset clears all entries to invalid. After reset: stall_f_o = stall_d_o = flush_e_o = 0, fwd_a_o = fwd_b_o = 0, counters = 0.
- Reset asserted mid-stall drops the stall immediately.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds outputs stall_cnt_o [31:0] and fwd_cnt_o [31:0].
  - stall_cnt_o increments on every lwstall cycle that is not overridden by ext_stall_i or flush_i.
  - fwd_cnt_o increments once per cycle in which fwd_a_o or fwd_b_o is nonzero and ext_stall_i is 0.
  - Both counters saturate at all-ones and reset to 0.
- HAZARD_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - typedef sb_entry_t (valid, wr, load, dst, rs, rt, use_rt);
  - the FW select encoding constant FWD_REGFILE = 0.
- One natural sub-module, fwd_select: a priority match of one source register against entries 1..DEPTH-1, instantiated twice (operand A and operand B).

## Test plan
All scenarios use DEPTH=3, LOAD_READY=2 unless stated.
- add $8 issued, then add $9,$8,$1 next cycle → fwd_a_o = 1 while the consumer is in E. One cycle later, with a different instruction issued instead, → fwd_a_o = 2.
- lw $8 then add $9,$1,$8 (use_rt = 1) → one cycle with stall_f_o = stall_d_o = flush_e_o = 1, then fwd_b_o = 2 and no further stall.
- lw $8 then addi $9,$1,... where the rt field equals 8 and use_rt = 0 → no stall; fwd_b_o = 0.
- add $0,... then add using $0 → fwd_a_o = fwd_b_o = 0 and no stall.
- lw-use pair with ext_stall_i held 3 cycles → stall_f_o = 1, flush_e_o = 0, scoreboard unchanged. After release, exactly one lwstall cycle follows.
- lw $8 in decode, then flush_i together with a dependent instruction in decode → no stall, entry 0 invalid, fwd selects 0.
- With LOAD_READY = 3, DEPTH = 4: lw $8 followed by a dependent instruction → a two-cycle stall, then fwd_a_o = 3.
